// File: rtl/frame_cfg_pkg.sv
// Shared types and constants for the column FrameStrobe sequencer.
// Field widths here are the defaults; instances may override them.
package frame_cfg_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

   localparam int unsigned CNT_W       = 4;
   localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;
   localparam int unsigned FRAME_SEL_W = 5;
   localparam int unsigned COL_SEL_W   = 5;
   localparam int unsigned FRAME_LSB   = 0;
   localparam int unsigned COL_LSB     = FRAME_LSB + FRAME_SEL_W;

   // The all-ones column value addresses every column at once.
   function automatic logic is_bcast_col(input int unsigned width, input logic [31:0] col);
      logic [31:0] ones;
      ones = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (col & ones) == ones;
   endfunction

endpackage

// File: rtl/frame_strobe_sequencer_decoder.sv
// Frame index to one-hot decoder with an in-range flag; purely combinational.
// Indices at or beyond MaxFramesPerCol decode to all zeros.
module frame_index_decoder
   import frame_cfg_pkg::*;
#(
   parameter int unsigned MaxFramesPerCol  = 20,
   parameter int unsigned FrameSelectWidth = FRAME_SEL_W
) (
   input  logic [FrameSelectWidth-1:0] idx_i,
   output logic [MaxFramesPerCol-1:0]  onehot_o,
   output logic                        in_range_o
);

   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < int'(MaxFramesPerCol); i++) begin
         onehot_o[i] = (int'(idx_i) == i);
      end
      in_range_o = int'(idx_i) < int'(MaxFramesPerCol);
   end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Column-level FrameStrobe driver: accepts frame-address words, and for this
// column issues one registered one-hot strobe after a FrameData setup window.
module frame_strobe_sequencer
   import frame_cfg_pkg::*;
#(
   parameter int unsigned MaxFramesPerCol  = 20,
   parameter int unsigned FrameSelectWidth = FRAME_SEL_W,
   parameter int unsigned ColSelectWidth   = COL_SEL_W,
   parameter int unsigned ColumnId         = 0,
   parameter int unsigned SetupCycles      = 2,
   parameter int unsigned StrobeCycles     = 1
) (
   input  logic                                     UserCLK,
   input  logic                                     rst,
   input  logic                                     addr_valid,
   output logic                                     addr_ready,
   input  logic [FrameSelectWidth+ColSelectWidth-1:0] addr_word,
   output logic [MaxFramesPerCol-1:0]               FrameStrobe,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     err_idx
);

   localparam int unsigned     ColLsb   = FrameSelectWidth;
   localparam logic [CNT_W-1:0] SetupLd  = CNT_W'(SetupCycles);
   localparam logic [CNT_W-1:0] StrobeLd = CNT_W'(StrobeCycles);

   generate
      if (SetupCycles > CNT_MAX || StrobeCycles == 0 || StrobeCycles > CNT_MAX) begin : g_bad_cfg
         $error("frame_strobe_sequencer: SetupCycles must be 0..15 and StrobeCycles 1..15");
      end
   endgenerate

   state_e                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [FrameSelectWidth-1:0]    idx_q, idx_d;
   logic [MaxFramesPerCol-1:0]     strobe_q, strobe_d;
   logic                           done_q, done_d;
   logic                           err_q, err_d;

   logic [FrameSelectWidth-1:0]    word_idx;
   logic [ColSelectWidth-1:0]      word_col;
   logic                           col_match, xfer, idx_ok;
   logic [MaxFramesPerCol-1:0]     idx_onehot;

   assign word_idx   = addr_word[FrameSelectWidth-1:0];
   assign word_col   = addr_word[ColLsb +: ColSelectWidth];
   assign col_match  = (word_col == ColSelectWidth'(ColumnId)) ||
                       is_bcast_col(ColSelectWidth, 32'(word_col));
   assign addr_ready = (state_q == IDLE) && !rst;
   assign xfer       = addr_valid && addr_ready;

   // Decoding idx_d lets one decoder serve both the range check at transfer
   // time and the strobe pattern held through STROBE.
   frame_index_decoder #(
      .MaxFramesPerCol (MaxFramesPerCol),
      .FrameSelectWidth(FrameSelectWidth)
   ) u_dec (
      .idx_i     (idx_d),
      .onehot_o  (idx_onehot),
      .in_range_o(idx_ok)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               idx_d = word_idx;
               if (col_match) begin
                  if (!idx_ok) begin
                     err_d = 1'b1;
                  end else if (SetupCycles == 0) begin
                     state_d = STROBE;
                     cnt_d   = StrobeLd;
                  end else begin
                     state_d = SETUP;
                     cnt_d   = SetupLd;
                  end
               end
            end
         end
         SETUP: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = STROBE;
               cnt_d   = StrobeLd;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         STROBE: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      strobe_d = (state_d == STROBE) ? idx_onehot : '0;
      done_d   = (state_d == HOLD);
   end

   always_ff @(posedge UserCLK) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         strobe_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge UserCLK) begin
      idx_q <= idx_d;
   end

   assign FrameStrobe = strobe_q;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign err_idx     = err_q;

endmodule
